// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: shared types, default timing and helpers for the HC-SR04 responder and distance front end.
package hcsr04_pkg;

    localparam int CNT_W = 24;

    localparam int unsigned CLK_HZ_DEF      = 40_000_000;
    localparam int unsigned MIN_TRIG_US_DEF = 10;
    localparam int unsigned BURST_US_DEF    = 200;
    localparam int unsigned MAX_ECHO_US_DEF = 38_000;
    localparam int unsigned HOLDOFF_US_DEF  = 2_000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG_HI = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] us_to_cycles(input int unsigned us, input int unsigned cpu);
        return CNT_W'(us * cpu);
    endfunction

endpackage

// File: rtl/hcsr04_responder_trig_sync.sv
// hcsr04_responder_trig_sync: 2-flop trig synchronizer with one-cycle rise/fall strobes.
module hcsr04_responder_trig_sync (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic trig_s,
    output logic rise,
    output logic fall
);

    // [0] first stage, [1] synchronized trig, [2] trig_s delayed one cycle; all reset high
    // so a trig held across reset never looks like a fresh rising edge.
    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], trig};
    end

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= sync_d;
    end

    assign trig_s = sync_q[1];
    assign rise   = sync_q[1] & ~sync_q[2];
    assign fall   = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/hcsr04_responder.sv
// hcsr04_responder: emulates an HC-SR04 sensor, answering a trig pulse with an echo whose width encodes echo_len_us.
module hcsr04_responder
    import hcsr04_pkg::*;
#(
    parameter int unsigned CLK_HZ        = CLK_HZ_DEF,
    parameter int unsigned CYCLES_PER_US = CLK_HZ / 1_000_000,
    parameter int unsigned MIN_TRIG_US   = MIN_TRIG_US_DEF,
    parameter int unsigned BURST_US      = BURST_US_DEF,
    parameter int unsigned MAX_ECHO_US   = MAX_ECHO_US_DEF,
    parameter int unsigned HOLDOFF_US    = HOLDOFF_US_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trig,
    input  logic [15:0] echo_len_us,
    output logic        echo,
    output logic        busy,
    output logic        short_trig,
    output logic        ignored
);

    localparam logic [CNT_W-1:0] MIN_CYC   = us_to_cycles(MIN_TRIG_US, CYCLES_PER_US);
    localparam logic [CNT_W-1:0] BURST_CYC = us_to_cycles(BURST_US, CYCLES_PER_US);
    localparam logic [CNT_W-1:0] HOLD_END  = us_to_cycles(HOLDOFF_US, CYCLES_PER_US) - CNT_W'(1);
    localparam logic [15:0]      MAX_LEN   = 16'(MAX_ECHO_US);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      len_q, len_d;
    logic             echo_q, echo_d;
    logic             short_q, short_d;
    logic             ign_q, ign_d;
    logic             trig_s, trig_rise, trig_fall;
    logic [CNT_W-1:0] echo_cyc;
    logic [15:0]      len_sel;

    hcsr04_responder_trig_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .trig   (trig),
        .trig_s (trig_s),
        .rise   (trig_rise),
        .fall   (trig_fall)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        echo_d   = echo_q;
        short_d  = 1'b0;
        ign_d    = 1'b0;
        echo_cyc = us_to_cycles(32'(len_q), CYCLES_PER_US);
        len_sel  = (echo_len_us == 16'd0 || echo_len_us > MAX_LEN) ? MAX_LEN : echo_len_us;
        case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    state_d = TRIG_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            TRIG_HI: begin
                if (trig_fall) begin
                    state_d = (cnt_q >= MIN_CYC) ? BURST : IDLE;
                    short_d = cnt_q < MIN_CYC;
                    cnt_d   = '0;
                    len_d   = (cnt_q >= MIN_CYC) ? len_sel : len_q;
                end else if (trig_s && cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // BURST lasts BURST_CYC+1 cycles so echo rises 3+BURST_CYC edges after trig is first sampled low.
            BURST: begin
                ign_d   = trig_rise;
                state_d = (cnt_q == BURST_CYC) ? ECHO : BURST;
                echo_d  = cnt_q == BURST_CYC;
                cnt_d   = (cnt_q == BURST_CYC) ? '0 : cnt_q + 1'b1;
            end
            ECHO: begin
                ign_d   = trig_rise;
                state_d = (cnt_q == echo_cyc - 1'b1) ? HOLDOFF : ECHO;
                echo_d  = cnt_q != echo_cyc - 1'b1;
                cnt_d   = (cnt_q == echo_cyc - 1'b1) ? '0 : cnt_q + 1'b1;
            end
            HOLDOFF: begin
                ign_d   = trig_rise;
                state_d = (cnt_q == HOLD_END) ? IDLE : HOLDOFF;
                cnt_d   = (cnt_q == HOLD_END) ? '0 : cnt_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                echo_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            echo_q  <= 1'b0;
            short_q <= 1'b0;
            ign_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            echo_q  <= echo_d;
            short_q <= short_d;
            ign_q   <= ign_d;
        end
    end

    assign echo       = echo_q;
    assign busy       = state_q inside {BURST, ECHO, HOLDOFF};
    assign short_trig = short_q;
    assign ignored    = ign_q;

endmodule

// File: tb/tb_hcsr04_responder.sv
// tb_hcsr04_responder: directed checks of trig/echo timing on a time-scaled responder.
module tb_hcsr04_responder;

    // Scaled timing: 4 cycles/us, min trig 40 cycles, burst 80, max echo 1200, holdoff 100.
    localparam int CPU     = 4;
    localparam int LAT     = 3 + 20 * CPU;
    localparam int HOLD    = 25 * CPU;
    localparam int MAX_CYC = 300 * CPU;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig = 1'b0;
    logic [15:0] echo_len_us = 16'd0;
    logic        echo, busy, short_trig, ignored;

    int n_cmp = 0;
    int n_bad = 0;
    int n_short = 0;
    int n_ign = 0;

    hcsr04_responder #(
        .CYCLES_PER_US (CPU),
        .MIN_TRIG_US   (10),
        .BURST_US      (20),
        .MAX_ECHO_US   (300),
        .HOLDOFF_US    (25)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trig        (trig),
        .echo_len_us (echo_len_us),
        .echo        (echo),
        .busy        (busy),
        .short_trig  (short_trig),
        .ignored     (ignored)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (short_trig) n_short++;
        if (ignored) n_ign++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int w);
        trig = 1'b1;
        repeat (w) @(negedge clk);
        trig = 1'b0;
    endtask

    // Called right after trig falls at a negedge; optionally pulses trig and changes
    // echo_len_us while echo is high.
    task automatic measure(input string tag, input int wid, input bit inj);
        int k;
        k = 0;
        while (!echo && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, k - 1, LAT);
        k = 0;
        while (echo && k < 5000) begin
            if (inj && k == 10) begin
                trig = 1'b1;
                echo_len_us = 16'd100;
            end
            if (inj && k == 58) trig = 1'b0;
            @(negedge clk);
            k++;
        end
        chk({tag, "_width"}, k, wid);
        chk({tag, "_busy_hold"}, int'(busy), 1);
        k = 0;
        while (busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_holdoff"}, k, HOLD);
    endtask

    initial begin
        int act, s0, i0;
        repeat (3) @(negedge clk);
        chk("rst_echo", int'(echo), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_short", int'(short_trig), 0);
        chk("rst_ign", int'(ignored), 0);
        reset = 1'b0;
        act = 0;
        repeat (100) begin
            @(negedge clk);
            act |= int'(echo | busy | short_trig | ignored);
        end
        chk("idle_quiet", act, 0);

        echo_len_us = 16'd58;
        pulse(48);
        measure("basic", 58 * CPU, 1'b0);

        s0 = n_short;
        pulse(20);
        act = 0;
        repeat (120) begin
            @(negedge clk);
            act |= int'(echo | busy);
        end
        chk("short_pulses", n_short - s0, 1);
        chk("short_no_activity", act, 0);

        s0 = n_short;
        pulse(39);
        repeat (10) @(negedge clk);
        chk("short39_pulses", n_short - s0, 1);
        chk("short39_busy", int'(busy), 0);

        s0 = n_short;
        echo_len_us = 16'd0;
        pulse(40);
        measure("len_zero", MAX_CYC, 1'b0);
        chk("min40_no_short", n_short - s0, 0);

        echo_len_us = 16'd40000;
        pulse(48);
        measure("len_big", MAX_CYC, 1'b0);

        i0 = n_ign;
        echo_len_us = 16'd58;
        pulse(48);
        measure("inj", 58 * CPU, 1'b1);
        chk("inj_ignored", n_ign - i0, 1);
        repeat (5) @(negedge clk);
        pulse(48);
        measure("next_len", 100 * CPU, 1'b0);

        echo_len_us = 16'd58;
        pulse(48);
        act = 0;
        while (!echo && act < 5000) begin
            @(negedge clk);
            act++;
        end
        repeat (20) @(negedge clk);
        chk("pre_rst_echo", int'(echo), 1);
        trig = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_echo", int'(echo), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        s0 = n_short;
        i0 = n_ign;
        act = 0;
        repeat (60) begin
            @(negedge clk);
            act |= int'(echo | busy);
        end
        trig = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_trig_activity", act | int'(busy), 0);
        chk("held_trig_short", n_short - s0, 0);
        chk("held_trig_ign", n_ign - i0, 0);
        pulse(48);
        measure("after_rst", 58 * CPU, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
